// File: rtl/ste_microwire.sv
// STE Microwire master: serialises the DATA/MASK register pair onto MWCLK/MWDATA/MWEN_N.
// Define LMC1992_EN to compile in the LMC1992 command decoder; otherwise volume/tone outputs are constants.
module ste_microwire (
    input  logic        clk32,
    input  logic        resb,
    input  logic        CS,
    input  logic [5:0]  A,
    input  logic        RW,
    input  logic [15:0] DIN,
    output logic [15:0] DOUT,
    output logic        BUSY,
    output logic        MWCLK,
    output logic        MWDATA,
    output logic        MWEN_N,
    output logic [5:0]  MASTER_VOL,
    output logic [4:0]  LEFT_VOL,
    output logic [4:0]  RIGHT_VOL,
    output logic [3:0]  BASS,
    output logic [3:0]  TREBLE,
    output logic [1:0]  MIX
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

    localparam logic [5:0] A_DATA  = 6'h11;
    localparam logic [5:0] A_MASK  = 6'h12;
    localparam logic [5:0] MV_RST  = 6'd40;
    localparam logic [4:0] LV_RST  = 5'd20;
    localparam logic [4:0] RV_RST  = 5'd20;
    localparam logic [3:0] BS_RST  = 4'd6;
    localparam logic [3:0] TR_RST  = 4'd6;
    localparam logic [1:0] MX_RST  = 2'd1;

    state_t      state_r, state_s;
    logic [15:0] data_r, data_s;
    logic [15:0] mask_r, mask_s;
    logic [4:0]  phase_r, phase_s;
    logic [3:0]  bit_r, bit_s;
    logic        wr_data_s, wr_mask_s, last_s;
    logic        busy_s, mwen_n_s, mwclk_s, mwdata_s;

    assign wr_data_s = CS & ~RW & (A == A_DATA) & (state_r == ST_IDLE);
    assign wr_mask_s = CS & ~RW & (A == A_MASK) & (state_r == ST_IDLE);
    assign last_s    = (state_r == ST_SHIFT) & (phase_r == 5'd31) & (bit_r == 4'd15);

    // FSM state register
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  if (wr_data_s) state_s = ST_SHIFT; else state_s = ST_IDLE;
            ST_SHIFT: if (last_s)    state_s = ST_IDLE;  else state_s = ST_SHIFT;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Datapath next values: CPU loads when idle, rotation at the end of every bit period
    always_comb begin
        data_s  = data_r;
        mask_s  = mask_r;
        phase_s = phase_r;
        bit_s   = bit_r;
        if (state_r == ST_IDLE) begin
            phase_s = 5'd0;
            bit_s   = 4'd0;
            if (wr_data_s) data_s = DIN; else data_s = data_r;
            if (wr_mask_s) mask_s = DIN; else mask_s = mask_r;
        end else begin
            phase_s = phase_r + 5'd1;
            if (phase_r == 5'd31) begin
                data_s = {data_r[14:0], data_r[15]};
                mask_s = {mask_r[14:0], mask_r[15]};
                bit_s  = bit_r + 4'd1;
            end else begin
                data_s = data_r;
                mask_s = mask_r;
                bit_s  = bit_r;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            data_r  <= 16'h0000;
            mask_r  <= 16'h0000;
            phase_r <= 5'd0;
            bit_r   <= 4'd0;
        end else begin
            data_r  <= data_s;
            mask_r  <= mask_s;
            phase_r <= phase_s;
            bit_r   <= bit_s;
        end
    end

    // FSM outputs, computed from next state so the pins are registered without extra latency
    always_comb begin
        busy_s   = (state_s == ST_SHIFT);
        mwen_n_s = ~busy_s;
        mwdata_s = busy_s & data_s[15];
        mwclk_s  = busy_s & mask_s[15] & (phase_s >= 5'd8) & (phase_s <= 5'd23);
    end

    // Registered Microwire pins and status
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            BUSY   <= 1'b0;
            MWEN_N <= 1'b1;
            MWDATA <= 1'b0;
            MWCLK  <= 1'b0;
        end else begin
            BUSY   <= busy_s;
            MWEN_N <= mwen_n_s;
            MWDATA <= mwdata_s;
            MWCLK  <= mwclk_s;
        end
    end

    // CPU read mux; reads have no side effects
    always_comb begin
        DOUT = 16'h0000;
        if (CS && RW) begin
            case (A)
                A_DATA:  DOUT = data_r;
                A_MASK:  DOUT = mask_r;
                default: DOUT = 16'h0000;
            endcase
        end else begin
            DOUT = 16'h0000;
        end
    end

`ifdef LMC1992_EN
    logic [10:0] sr_r;
    logic [4:0]  cnt_r;
    logic        mwen_d_r;
    logic        capture_s, mwen_rise_s;
    logic [5:0]  master_vol_r;
    logic [4:0]  left_vol_r, right_vol_r;
    logic [3:0]  bass_r, treble_r;
    logic [1:0]  mix_r;

    function automatic logic cmd_ok(input logic [4:0] cnt, input logic [10:0] sr);
        return (cnt >= 5'd11) && (sr[10:9] == 2'b10);
    endfunction

    // Capture happens on the cycle MWCLK is first high within a bit period
    assign capture_s   = (state_r == ST_SHIFT) & (phase_r == 5'd8) & mask_r[15];
    assign mwen_rise_s = MWEN_N & ~mwen_d_r;

    // Received-bit shift register and saturating bit count
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            sr_r     <= 11'd0;
            cnt_r    <= 5'd0;
            mwen_d_r <= 1'b1;
        end else begin
            mwen_d_r <= MWEN_N;
            if (wr_data_s) begin
                cnt_r <= 5'd0;
            end else if (capture_s) begin
                sr_r <= {sr_r[9:0], data_r[15]};
                if (cnt_r != 5'd16) cnt_r <= cnt_r + 5'd1;
            end
        end
    end

    // Command execution when the enable is released
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            master_vol_r <= MV_RST;
            left_vol_r   <= LV_RST;
            right_vol_r  <= RV_RST;
            bass_r       <= BS_RST;
            treble_r     <= TR_RST;
            mix_r        <= MX_RST;
        end else if (mwen_rise_s && cmd_ok(cnt_r, sr_r)) begin
            case (sr_r[8:6])
                3'b000:  mix_r        <= sr_r[1:0];
                3'b001:  bass_r       <= sr_r[3:0];
                3'b010:  treble_r     <= sr_r[3:0];
                3'b011:  master_vol_r <= sr_r[5:0];
                3'b100:  right_vol_r  <= sr_r[4:0];
                3'b101:  left_vol_r   <= sr_r[4:0];
                default: ;
            endcase
        end
    end

    assign MASTER_VOL = master_vol_r;
    assign LEFT_VOL   = left_vol_r;
    assign RIGHT_VOL  = right_vol_r;
    assign BASS       = bass_r;
    assign TREBLE     = treble_r;
    assign MIX        = mix_r;
`else
    assign MASTER_VOL = MV_RST;
    assign LEFT_VOL   = LV_RST;
    assign RIGHT_VOL  = RV_RST;
    assign BASS       = BS_RST;
    assign TREBLE     = TR_RST;
    assign MIX        = MX_RST;
`endif

endmodule

// File: tb/tb_ste_microwire.sv
// Directed testbench for ste_microwire; decoded-output expectations follow the LMC1992_EN build option.
module tb_ste_microwire;

    logic        clk32, resb, CS, RW;
    logic [5:0]  A;
    logic [15:0] DIN, DOUT;
    logic        BUSY, MWCLK, MWDATA, MWEN_N;
    logic [5:0]  MASTER_VOL;
    logic [4:0]  LEFT_VOL, RIGHT_VOL;
    logic [3:0]  BASS, TREBLE;
    logic [1:0]  MIX;

    int vectors = 0;
    int miscompares = 0;

    logic [5:0] e_mv;
    logic [4:0] e_lv, e_rv;
    logic [3:0] e_bs, e_tr;
    logic [1:0] e_mx;

    ste_microwire dut (
        .clk32(clk32), .resb(resb), .CS(CS), .A(A), .RW(RW), .DIN(DIN), .DOUT(DOUT),
        .BUSY(BUSY), .MWCLK(MWCLK), .MWDATA(MWDATA), .MWEN_N(MWEN_N),
        .MASTER_VOL(MASTER_VOL), .LEFT_VOL(LEFT_VOL), .RIGHT_VOL(RIGHT_VOL),
        .BASS(BASS), .TREBLE(TREBLE), .MIX(MIX)
    );

    initial begin
        clk32 = 1'b0;
        forever #15 clk32 = ~clk32;
    end

    task automatic write_reg(input logic [5:0] a, input logic [15:0] d);
        @(negedge clk32);
        CS = 1'b1; RW = 1'b0; A = a; DIN = d;
        @(posedge clk32); #1;
        CS = 1'b0; RW = 1'b1;
    endtask

    task automatic read_reg(input logic [5:0] a, output logic [15:0] d);
        CS = 1'b1; RW = 1'b1; A = a;
        #2;
        d = DOUT;
        CS = 1'b0;
    endtask

    // Starts a transfer and measures it; returns at T+513 (first cycle with MWEN_N high)
    task automatic run_transfer(input logic [15:0] mask, input logic [15:0] data,
                                input int inj_n, input logic [15:0] inj_d,
                                output int en_low, output int pulses, output int first,
                                output int hi, output int bad_bits, output logic [15:0] rd33);
        int n;
        logic prev_clk;
        write_reg(6'h12, mask);
        write_reg(6'h11, data);
        n = 1; en_low = 0; pulses = 0; first = 0; hi = 0; bad_bits = 0; prev_clk = 1'b0; rd33 = 16'hxxxx;
        while (MWEN_N == 1'b0 && n < 700) begin
            en_low++;
            if (MWCLK) hi++;
            if (MWCLK && !prev_clk) begin
                pulses++;
                if (first == 0) first = n;
            end
            prev_clk = MWCLK;
            if (n <= 512 && ((n - 1) % 32) == 0 && MWDATA !== data[15 - (n - 1) / 32]) bad_bits++;
            if (n == 33) read_reg(6'h11, rd33);
            if (n == inj_n) begin
                @(negedge clk32);
                CS = 1'b1; RW = 1'b0; A = 6'h11; DIN = inj_d;
            end
            @(posedge clk32); #1;
            if (n == inj_n) begin CS = 1'b0; RW = 1'b1; end
            n++;
        end
    endtask

    task automatic test_reset;
        logic [15:0] d;
        resb = 1'b0; CS = 1'b0; RW = 1'b1; A = 6'h00; DIN = 16'h0000;
        repeat (3) @(posedge clk32);
        @(negedge clk32); resb = 1'b1;
        @(posedge clk32); #1;
        e_mv = 6'd40; e_lv = 5'd20; e_rv = 5'd20; e_bs = 4'd6; e_tr = 4'd6; e_mx = 2'd1;
        vectors++; if (MWEN_N !== 1'b1) begin miscompares++; $display("FAIL reset_mwen_n got %b want 1", MWEN_N); end
        vectors++; if (MWCLK !== 1'b0) begin miscompares++; $display("FAIL reset_mwclk got %b want 0", MWCLK); end
        vectors++; if (MWDATA !== 1'b0) begin miscompares++; $display("FAIL reset_mwdata got %b want 0", MWDATA); end
        vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", BUSY); end
        vectors++; if (DOUT !== 16'h0000) begin miscompares++; $display("FAIL reset_dout_idle got %h want 0000", DOUT); end
        vectors++;
        if ({MASTER_VOL, LEFT_VOL, RIGHT_VOL, BASS, TREBLE, MIX} !== {e_mv, e_lv, e_rv, e_bs, e_tr, e_mx}) begin
            miscompares++;
            $display("FAIL reset_decoded got %h want %h", {MASTER_VOL, LEFT_VOL, RIGHT_VOL, BASS, TREBLE, MIX},
                     {e_mv, e_lv, e_rv, e_bs, e_tr, e_mx});
        end
        read_reg(6'h11, d);
        vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL reset_data_reg got %h want 0000", d); end
    endtask

    task automatic test_master_vol;
        int en_low, pulses, first, hi, bad;
        logic [15:0] r33, d;
        run_transfer(16'h07FF, 16'h04D4, 0, 16'h0000, en_low, pulses, first, hi, bad, r33);
        vectors++; if (en_low != 512) begin miscompares++; $display("FAIL mv_enable_low got %0d want 512", en_low); end
        vectors++; if (pulses != 11) begin miscompares++; $display("FAIL mv_pulses got %0d want 11", pulses); end
        vectors++; if (first != 169) begin miscompares++; $display("FAIL mv_first_rise got %0d want 169", first); end
        vectors++; if (hi != 176) begin miscompares++; $display("FAIL mv_clk_high got %0d want 176", hi); end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL mv_data_bits got %0d bad want 0", bad); end
        vectors++; if (r33 !== 16'h09A8) begin miscompares++; $display("FAIL mv_read_t33 got %h want 09a8", r33); end
        vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL mv_busy_end got %b want 0", BUSY); end
        @(posedge clk32); #1;
`ifdef LMC1992_EN
        e_mv = 6'd20;
`endif
        vectors++; if (MASTER_VOL !== e_mv) begin miscompares++; $display("FAIL mv_master_vol got %0d want %0d", MASTER_VOL, e_mv); end
        read_reg(6'h11, d);
        vectors++; if (d !== 16'h04D4) begin miscompares++; $display("FAIL mv_data_after got %h want 04d4", d); end
    endtask

    task automatic test_rotation;
        int en_low, pulses, first, hi, bad;
        logic [15:0] r33, d;
        run_transfer(16'h07FF, 16'h054F, 0, 16'h0000, en_low, pulses, first, hi, bad, r33);
        vectors++; if (r33 !== 16'h0A9E) begin miscompares++; $display("FAIL rot_read_t33 got %h want 0a9e", r33); end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL rot_data_bits got %0d bad want 0", bad); end
        @(posedge clk32); #1;
`ifdef LMC1992_EN
        e_lv = 5'd15;
`endif
        vectors++;
        if ({MASTER_VOL, LEFT_VOL, RIGHT_VOL, BASS, TREBLE, MIX} !== {e_mv, e_lv, e_rv, e_bs, e_tr, e_mx}) begin
            miscompares++;
            $display("FAIL rot_decoded got %h want %h", {MASTER_VOL, LEFT_VOL, RIGHT_VOL, BASS, TREBLE, MIX},
                     {e_mv, e_lv, e_rv, e_bs, e_tr, e_mx});
        end
        read_reg(6'h12, d);
        vectors++; if (d !== 16'h07FF) begin miscompares++; $display("FAIL rot_mask_read got %h want 07ff", d); end
        read_reg(6'h13, d);
        vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL rot_unmapped_read got %h want 0000", d); end
    endtask

    task automatic test_busy_write;
        int en_low, pulses, first, hi, bad;
        logic [15:0] r33, d;
        run_transfer(16'h07FF, 16'h04CA, 100, 16'h1234, en_low, pulses, first, hi, bad, r33);
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL busy_data_bits got %0d bad want 0", bad); end
        vectors++; if (en_low != 512) begin miscompares++; $display("FAIL busy_enable_low got %0d want 512", en_low); end
        @(posedge clk32); #1;
`ifdef LMC1992_EN
        e_mv = 6'd10;
`endif
        vectors++; if (MASTER_VOL !== e_mv) begin miscompares++; $display("FAIL busy_master_vol got %0d want %0d", MASTER_VOL, e_mv); end
        read_reg(6'h11, d);
        vectors++; if (d !== 16'h04CA) begin miscompares++; $display("FAIL busy_data_after got %h want 04ca", d); end
    endtask

    task automatic test_short_cmd;
        int en_low, pulses, first, hi, bad;
        logic [15:0] r33;
        run_transfer(16'h00FF, 16'h04E8, 0, 16'h0000, en_low, pulses, first, hi, bad, r33);
        vectors++; if (pulses != 8) begin miscompares++; $display("FAIL short_pulses got %0d want 8", pulses); end
        vectors++; if (first != 265) begin miscompares++; $display("FAIL short_first_rise got %0d want 265", first); end
        @(posedge clk32); #1;
        vectors++;
        if ({MASTER_VOL, LEFT_VOL, RIGHT_VOL, BASS, TREBLE, MIX} !== {e_mv, e_lv, e_rv, e_bs, e_tr, e_mx}) begin
            miscompares++;
            $display("FAIL short_decoded got %h want %h", {MASTER_VOL, LEFT_VOL, RIGHT_VOL, BASS, TREBLE, MIX},
                     {e_mv, e_lv, e_rv, e_bs, e_tr, e_mx});
        end
    endtask

    task automatic test_final_cycle_write;
        int en_low, pulses, first, hi, bad;
        logic [15:0] r33, d;
        run_transfer(16'h07FF, 16'h0561, 512, 16'h04D4, en_low, pulses, first, hi, bad, r33);
        vectors++; if (en_low != 512) begin miscompares++; $display("FAIL final_enable_low got %0d want 512", en_low); end
        @(posedge clk32); #1;
        vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL final_busy_t514 got %b want 0", BUSY); end
`ifdef LMC1992_EN
        e_lv = 5'd1;
`endif
        vectors++; if (LEFT_VOL !== e_lv) begin miscompares++; $display("FAIL final_left_vol got %0d want %0d", LEFT_VOL, e_lv); end
        read_reg(6'h11, d);
        vectors++; if (d !== 16'h0561) begin miscompares++; $display("FAIL final_data_after got %h want 0561", d); end
    endtask

    task automatic test_reset_mid;
        int en_low, pulses, first, hi, bad;
        logic [15:0] r33, d;
        write_reg(6'h12, 16'h07FF);
        write_reg(6'h11, 16'h04D4);
        repeat (199) @(posedge clk32);
        #1;
        vectors++; if (MWEN_N !== 1'b0) begin miscompares++; $display("FAIL rmid_active got %b want 0", MWEN_N); end
        resb = 1'b0;
        #1;
        vectors++; if (MWEN_N !== 1'b1) begin miscompares++; $display("FAIL rmid_mwen_n got %b want 1", MWEN_N); end
        vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got %b want 0", BUSY); end
        read_reg(6'h11, d);
        vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL rmid_data got %h want 0000", d); end
        repeat (2) @(posedge clk32);
        @(negedge clk32); resb = 1'b1;
        repeat (3) @(posedge clk32);
        #1;
        e_mv = 6'd40; e_lv = 5'd20; e_rv = 5'd20; e_bs = 4'd6; e_tr = 4'd6; e_mx = 2'd1;
        vectors++;
        if ({MASTER_VOL, LEFT_VOL, RIGHT_VOL, BASS, TREBLE, MIX} !== {e_mv, e_lv, e_rv, e_bs, e_tr, e_mx}) begin
            miscompares++;
            $display("FAIL rmid_decoded got %h want %h", {MASTER_VOL, LEFT_VOL, RIGHT_VOL, BASS, TREBLE, MIX},
                     {e_mv, e_lv, e_rv, e_bs, e_tr, e_mx});
        end
        run_transfer(16'h07FF, 16'h0526, 0, 16'h0000, en_low, pulses, first, hi, bad, r33);
        vectors++; if (pulses != 11) begin miscompares++; $display("FAIL rmid_clean_pulses got %0d want 11", pulses); end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL rmid_clean_bits got %0d bad want 0", bad); end
        @(posedge clk32); #1;
`ifdef LMC1992_EN
        e_rv = 5'd6;
`endif
        vectors++;
        if ({MASTER_VOL, LEFT_VOL, RIGHT_VOL, BASS, TREBLE, MIX} !== {e_mv, e_lv, e_rv, e_bs, e_tr, e_mx}) begin
            miscompares++;
            $display("FAIL rmid_clean_decoded got %h want %h", {MASTER_VOL, LEFT_VOL, RIGHT_VOL, BASS, TREBLE, MIX},
                     {e_mv, e_lv, e_rv, e_bs, e_tr, e_mx});
        end
    endtask

    initial begin
        test_reset;
        test_master_vol;
        test_rotation;
        test_busy_write;
        test_short_cmd;
        test_final_cycle_write;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ste_microwire.md
# ste_microwire

STE Microwire master with an optional LMC1992 command decoder. It sits downstream of the GST shifter's CPU register window in the STE top level and shares the shifter's chip select and address lines. It serialises the 16-bit Microwire data/mask register pair onto MWCLK/MWDATA/MWEN_N. It also decodes LMC1992 volume/tone commands into parallel control words for the audio mixer that consumes the shifter's DMA sound samples.

## Interface
- No parameters. Bit period is fixed at 32 clk32 cycles (1 MHz).
- clk32 input 1 — system clock, 32 MHz, all logic rising-edge.
- resb input 1 — reset, asynchronous, active-low.
- CS input 1 — register window select, active-high, from ~CMPCS_N.
- A input 6 — CPU address A[6:1]. Word 0x11 = data register ($FF8922), word 0x12 = mask register ($FF8924).
- RW input 1 — 1 = read, 0 = write.
- DIN input 16 — CPU write data.
- DOUT output 16 — read data. Driven only when CS & RW and A selects a register; 16'h0000 otherwise.
- BUSY output 1 — transfer in progress.
- MWCLK output 1 — Microwire clock.
- MWDATA output 1 — Microwire data, MSB first.
- MWEN_N output 1 — Microwire enable, low during transfer.
- MASTER_VOL output 6 — LMC1992 master volume.
- LEFT_VOL output 5 — LMC1992 left volume.
- RIGHT_VOL output 5 — LMC1992 right volume.
- BASS output 4 — LMC1992 bass setting.
- TREBLE output 4 — LMC1992 treble setting.
- MIX output 2 — LMC1992 input mix select.

## Operation
- Registers
  - DATA and MASK are 16-bit. Both reset to 0.
  - A CPU write (CS & ~RW) to MASK loads DIN when the block is idle.
  - A CPU write to DATA loads DIN and starts a transfer when the block is idle.
  - Writes to either register while BUSY are ignored.
  - Reads return the current register content, including mid-rotation values, with no side effects.
- Transfer FSM
  - States: IDLE → SHIFT → IDLE.
  - In SHIFT, a 5-bit phase counter runs 0..31 and a 4-bit bit counter runs 0..15.
  - MWDATA = DATA[15] for the whole bit period.
  - MWCLK is high for phases 8..23 when MASK[15]=1, and stays low otherwise.
  - At phase 31, DATA and MASK both rotate left by 1.
  - After the 16th rotation both registers hold their pre-transfer values, and the FSM returns to IDLE.
- LMC1992 decoder (only when LMC1992_EN is defined)
  - Shifts MWDATA into an 11-bit shift register at each MWCLK rising edge (phase 8 with MASK[15]=1).
  - A 5-bit received-bit counter saturates at 16.
  - On the MWEN_N rising edge:
    - A command is accepted if count ≥ 11 and sr[10:9] = 2'b10. The last 11 bits received are used.
    - Function sr[8:6] selects the target: 000 MIX ← sr[1:0]; 001 BASS ← sr[3:0]; 010 TREBLE ← sr[3:0]; 011 MASTER_VOL ← sr[5:0]; 100 RIGHT_VOL ← sr[4:0]; 101 LEFT_VOL ← sr[4:0].
    - Functions 110 and 111 are ignored.
  - On any failed check, the command is dropped and no output changes.
- Reset values
  - DOUT 0, BUSY 0, MWCLK 0, MWDATA 0, MWEN_N 1.
  - MASTER_VOL 6'd40 (0 dB), LEFT_VOL 5'd20, RIGHT_VOL 5'd20, BASS 4'd6, TREBLE 4'd6, MIX 2'd1.
- Reset mid-transfer
  - All state and outputs return to reset values immediately; MWEN_N goes high asynchronously.
  - The partial command is discarded.

## Timing
- The write is sampled at clk32 edge T. At T+1: BUSY=1, MWEN_N=0, phase=0, MWDATA=DATA[15].
- Bit k spans cycles T+1+32k .. T+32+32k.
- MWCLK rises at T+9+32k and falls at T+25+32k.
- MWEN_N=1 and BUSY=0 at T+513, i.e. 512 cycles of enable low.
- A new DATA write is accepted from T+513 onward.
- Decoded outputs update at T+514, one cycle after MWEN_N rises.
- DOUT is combinational from the register state.
- A write that coincides with the final rotation cycle (T+512) is ignored.

## Configuration
- LMC1992_EN defined: the decoder is compiled in, and the volume/tone outputs follow accepted commands.
- LMC1992_EN undefined: no decoder logic; the volume/tone outputs are tied to their reset values. Microwire pins and registers are unchanged.

## Test plan
- Reset → MWEN_N=1, MWCLK=0, BUSY=0, MASTER_VOL=40, BASS=6, MIX=1.
- MASK=0x07FF, DATA=0x04D4 → five MWCLK-less bit periods, then 11 pulses. MWEN_N is low 512 cycles, and MASTER_VOL=20 at T+514. DATA reads 0x04D4 afterwards.
- MASK=0x07FF, DATA=0x054F → LEFT_VOL=15. A DATA read at T+33 returns 0x0A9E (one rotation).
- DATA=0x1234 written at T+100 of an active transfer → ignored. The second transfer carries the original data, and the register holds the original value.
- MASK=0x00FF, DATA=0x04E8 (only 8 clocks) → no output changes.
- resb low at T+200 → MWEN_N=1 at once, no decoded change, DATA=0. A following write starts a clean transfer.
